// File: rtl/layer_sequencer_if.sv
// Bus bundle between the layer sequencer, its controller and the RAM wrappers.
//   start/relu_en : pass request and ReLU select from the inference controller
//   busy/done     : pass status back to the controller
//   w_address/w_q : one address/read-data pair per weight/bias lane RAM
//   io_address/io_d/io_wren/io_q : shared input/output activation RAM port
// master = sequencer side, slave = controller + RAM side.
interface layer_sequencer_if #(
    parameter int unsigned N_LANES = 20,
    parameter int unsigned AW      = 10,
    parameter int unsigned DW      = 16
);
    logic                           start;
    logic                           relu_en;
    logic                           busy;
    logic                           done;
    logic [N_LANES-1:0][AW-1:0]     w_address;
    logic [N_LANES-1:0][DW-1:0]     w_q;
    logic [AW-1:0]                  io_address;
    logic [DW-1:0]                  io_d;
    logic                           io_wren;
    logic [DW-1:0]                  io_q;

    modport master (
        input  start, relu_en, w_q, io_q,
        output busy, done, w_address, io_address, io_d, io_wren
    );

    modport slave (
        output start, relu_en, w_q, io_q,
        input  busy, done, w_address, io_address, io_d, io_wren
    );
endinterface

// File: rtl/layer_sequencer.sv
// One fully-connected 20-neuron layer pass.
// Streams the input vector and per-lane weights out of the RAMs, accumulates
// 20 Q8.8 dot products in parallel in 40-bit accumulators, adds biases,
// optionally applies ReLU and writes the 20 saturated results to the IO RAM.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, abandons any pass in flight
//   bus   : layer_sequencer_if.master (start/relu_en in, busy/done out,
//           weight lane addresses/data, IO RAM address/data/write enable)
module layer_sequencer #(
    parameter int unsigned N_IN     = 784,
    parameter int unsigned IN_BASE  = 0,
    parameter int unsigned OUT_BASE = 784,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    layer_sequencer_if.master   bus
);

    localparam int unsigned NL      = 20;
    localparam int unsigned AW      = 10;
    localparam int unsigned DW      = 16;
    localparam int unsigned PW      = 32;
    localparam int unsigned ACCW    = 40;
    localparam int unsigned CNT_MAX = ((N_IN + 1) > NL) ? (N_IN + 1) : NL;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned LW      = $clog2(NL);

    localparam logic signed [ACCW-1:0] SAT_HI = ACCW'(32'sd32767);
    localparam logic signed [ACCW-1:0] SAT_LO = ACCW'(-32'sd32768);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic                   relu_q;
    logic                   busy_q;
    logic                   done_q;
    logic [AW-1:0]          w_addr_q;
    logic [AW-1:0]          io_addr_q;
    logic [DW-1:0]          io_d_q;
    logic                   io_wren_q;

    logic [RD_LAT-1:0]      tag_v;
    logic [CW-1:0]          tag_i [RD_LAT];
    logic signed [ACCW-1:0] acc     [NL];
    logic signed [ACCW-1:0] acc_nxt [NL];

    logic [LW-1:0]          lane_sel;
    logic [DW-1:0]          res_c;
    logic                   accept_c;

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.w_address  = {NL{w_addr_q}};
    assign bus.io_address = io_addr_q;
    assign bus.io_d       = io_d_q;
    assign bus.io_wren    = io_wren_q;

    assign accept_c = (state == S_IDLE) && bus.start;

    // Rescale Q16.16 to Q8.8, saturate on the full accumulator, then ReLU.
    function automatic logic [DW-1:0] post(input logic signed [ACCW-1:0] a,
                                           input logic relu);
        logic signed [ACCW-1:0] r;
        logic [DW-1:0]          y;
        r = a >>> 8;
        if (r > SAT_HI) begin
            y = 16'h7FFF;
        end else if (r < SAT_LO) begin
            y = 16'h8000;
        end else begin
            y = r[DW-1:0];
        end
        if (relu && r[ACCW-1]) begin
            y = '0;
        end
        return y;
    endfunction

    // MAC / bias update driven by the tag emerging from the read pipeline.
    always_comb begin
        for (int n = 0; n < NL; n++) begin
            acc_nxt[n] = acc[n];
            if (tag_v[RD_LAT-1]) begin
                if (tag_i[RD_LAT-1] == CW'(N_IN)) begin
                    acc_nxt[n] = acc[n] + (ACCW'($signed(bus.w_q[n])) <<< 8);
                end else begin
                    acc_nxt[n] = acc[n] + ACCW'(PW'($signed(bus.io_q)) *
                                                PW'($signed(bus.w_q[n])));
                end
            end
        end
    end

    // Lane whose result is loaded into io_d at the coming edge; the bias of the
    // last read lands in the same edge as lane 0's load, hence acc_nxt.
    always_comb begin
        lane_sel = '0;
        if (state == S_WRITE && cnt < CW'(NL - 1)) begin
            lane_sel = LW'(cnt + CW'(1));
        end
        res_c = post(acc_nxt[lane_sel], relu_q);
    end

    // Sequencing FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            relu_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            w_addr_q  <= '0;
            io_addr_q <= '0;
            io_d_q    <= '0;
            io_wren_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    io_wren_q <= 1'b0;
                    done_q    <= 1'b0;
                    if (bus.start) begin
                        state     <= S_READ;
                        relu_q    <= bus.relu_en;
                        busy_q    <= 1'b1;
                        cnt       <= '0;
                        w_addr_q  <= '0;
                        io_addr_q <= AW'(IN_BASE);
                    end
                end
                S_READ: begin
                    if (cnt == CW'(N_IN)) begin
                        state     <= S_DRAIN;
                        cnt       <= '0;
                        w_addr_q  <= '0;
                        io_addr_q <= '0;
                    end else begin
                        cnt      <= cnt + CW'(1);
                        w_addr_q <= AW'(cnt + CW'(1));
                        // The bias slot has no input element; park on IN_BASE.
                        if (cnt + CW'(1) == CW'(N_IN)) begin
                            io_addr_q <= AW'(IN_BASE);
                        end else begin
                            io_addr_q <= AW'(IN_BASE) + AW'(cnt + CW'(1));
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt == CW'(RD_LAT - 1)) begin
                        state     <= S_WRITE;
                        cnt       <= '0;
                        io_wren_q <= 1'b1;
                        io_addr_q <= AW'(OUT_BASE);
                        io_d_q    <= res_c;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WRITE: begin
                    if (cnt == CW'(NL - 1)) begin
                        state     <= S_DONE;
                        cnt       <= '0;
                        done_q    <= 1'b1;
                        io_wren_q <= 1'b0;
                        io_addr_q <= '0;
                        io_d_q    <= '0;
                    end else begin
                        cnt       <= cnt + CW'(1);
                        io_addr_q <= AW'(OUT_BASE) + AW'(cnt + CW'(1));
                        io_d_q    <= res_c;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Read tag pipeline and accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_i[k] <= '0;
            end
            for (int n = 0; n < NL; n++) begin
                acc[n] <= '0;
            end
        end else begin
            tag_v[0] <= (state == S_READ);
            tag_i[0] <= cnt;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            for (int n = 0; n < NL; n++) begin
                acc[n] <= accept_c ? '0 : acc_nxt[n];
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer (N_IN=4, RD_LAT=2).
// RAM models with registered address and registered q; a scoreboard queue of
// expected IO RAM writes is filled when a pass is started and drained by a
// write monitor.
module tb_layer_sequencer;

    localparam int unsigned N_IN     = 4;
    localparam int unsigned IN_BASE  = 0;
    localparam int unsigned OUT_BASE = 784;
    localparam int unsigned RD_LAT   = 2;
    localparam int unsigned NL       = 20;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] data;
    } exp_t;

    logic clk;
    logic rst_n;

    layer_sequencer_if bus ();

    layer_sequencer #(
        .N_IN     (N_IN),
        .IN_BASE  (IN_BASE),
        .OUT_BASE (OUT_BASE),
        .RD_LAT   (RD_LAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0]       io_mem [1024];
    logic [15:0]       w_mem  [NL][1024];
    logic [9:0]        io_a_r;
    logic [NL-1:0][9:0] w_a_r;

    exp_t sb [$];
    exp_t e;
    int   n_tests;
    int   n_fail;
    int   wren_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: address registered, then q registered.
    always @(posedge clk) begin
        bus.io_q <= io_mem[io_a_r];
        for (int n = 0; n < NL; n++) begin
            bus.w_q[n] <= w_mem[n][w_a_r[n]];
        end
        io_a_r <= bus.io_address;
        w_a_r  <= bus.w_address;
        if (bus.io_wren) begin
            io_mem[bus.io_address] = bus.io_d;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input int lane, input bit relu);
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < N_IN; i++) begin
            acc += longint'($signed(io_mem[IN_BASE + i])) *
                   longint'($signed(w_mem[lane][i]));
        end
        acc += longint'($signed(w_mem[lane][N_IN])) * 256;
        r = acc >>> 8;
        if (r > 32767)       r = 32767;
        else if (r < -32768) r = -32768;
        if (relu && r < 0)   r = 0;
        return 16'(r);
    endfunction

    task automatic push_expected(input bit relu);
        exp_t x;
        for (int n = 0; n < NL; n++) begin
            x.addr = 10'(OUT_BASE + n);
            x.data = model(n, relu);
            sb.push_back(x);
        end
    endtask

    // Write monitor: every IO RAM write must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.io_wren) begin
            wren_cnt++;
            if (sb.size() == 0) begin
                check_eq("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check_eq("wr_addr", 64'(bus.io_address), 64'(e.addr));
                check_eq("wr_data", 64'(bus.io_d), 64'(e.data));
            end
        end
    end

    // One pass: address trace, Done/Busy timing, ignored Start pulses.
    // hold keeps Start high so a second pass follows back-to-back.
    task automatic run_pass(input bit relu, input bit toggle, input bit hold);
        int cyc;
        int done_at;
        int busy_cnt;
        int w0;
        int k;
        push_expected(relu);
        if (hold) push_expected(relu);
        w0 = wren_cnt;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.relu_en = relu;
        @(negedge clk);
        cyc = 1;
        if (!hold) bus.start = 1'b0;
        if (toggle) bus.relu_en = ~relu;
        done_at  = 0;
        busy_cnt = 0;
        while (done_at == 0 && cyc <= 100) begin
            if (cyc <= N_IN + 1) begin
                for (int n = 0; n < NL; n++) begin
                    check_eq("w_addr_trace", 64'(bus.w_address[n]), 64'(cyc - 1));
                end
                check_eq("io_addr_trace", 64'(bus.io_address),
                         (cyc - 1 < N_IN) ? 64'(IN_BASE + cyc - 1) : 64'(IN_BASE));
            end
            if (bus.busy && !bus.done) busy_cnt++;
            if (bus.done) done_at = cyc;
            if (!hold) bus.start = (cyc == 3 || cyc == 12 || cyc == 25);
            @(negedge clk);
            cyc++;
        end
        check_eq("done_cycle", 64'(done_at), 64'(N_IN + RD_LAT + 22));
        check_eq("busy_cycles", 64'(busy_cnt), 64'(N_IN + RD_LAT + 21));
        check_eq("idle_busy", 64'(bus.busy), 64'd0);
        check_eq("idle_done", 64'(bus.done), 64'd0);
        check_eq("idle_wren", 64'(bus.io_wren), 64'd0);
        if (hold) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_eq("b2b_busy", 64'(bus.busy), 64'd1);
            k = 0;
            while (!bus.done && k < 100) begin
                @(negedge clk);
                k++;
            end
            check_eq("b2b_done", 64'(bus.done), 64'd1);
            @(negedge clk);
        end
        check_eq("wren_count", 64'(wren_cnt - w0), hold ? 64'd40 : 64'd20);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        wren_cnt    = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.relu_en = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            io_mem[a] = '0;
            for (int n = 0; n < NL; n++) w_mem[n][a] = 16'($urandom);
        end
        for (int i = 0; i < N_IN; i++) begin
            io_mem[IN_BASE + i] = 16'((i + 1) * 256);
            w_mem[0][i] = 16'h0100;
            w_mem[1][i] = 16'h0080;
            w_mem[2][i] = 16'hFF00;
        end
        w_mem[0][N_IN] = 16'h0080;
        w_mem[1][N_IN] = 16'h0000;
        w_mem[2][N_IN] = 16'h0000;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_done", 64'(bus.done), 64'd0);
        check_eq("rst_wren", 64'(bus.io_wren), 64'd0);
        check_eq("rst_io_addr", 64'(bus.io_address), 64'd0);
        check_eq("rst_io_d", 64'(bus.io_d), 64'd0);
        check_eq("rst_w_addr", 64'(|bus.w_address), 64'd0);
        rst_n = 1'b1;

        // Basic MAC, negative result without ReLU.
        run_pass(1'b0, 1'b0, 1'b0);
        check_eq("mac_lane0", 64'(io_mem[OUT_BASE + 0]), 64'h0A80);
        check_eq("mac_lane1", 64'(io_mem[OUT_BASE + 1]), 64'h0500);
        check_eq("neg_lane2", 64'(io_mem[OUT_BASE + 2]), 64'hF600);

        // ReLU captured at Start; toggling afterwards must not matter.
        run_pass(1'b1, 1'b1, 1'b0);
        check_eq("relu_lane2", 64'(io_mem[OUT_BASE + 2]), 64'h0000);
        check_eq("relu_lane0", 64'(io_mem[OUT_BASE + 0]), 64'h0A80);

        // Saturation both ways.
        for (int i = 0; i < N_IN; i++) begin
            io_mem[IN_BASE + i] = 16'h7FFF;
            w_mem[0][i] = 16'h7FFF;
            w_mem[1][i] = 16'h8001;
        end
        w_mem[0][N_IN] = 16'h0000;
        w_mem[1][N_IN] = 16'h0000;
        run_pass(1'b0, 1'b0, 1'b0);
        check_eq("sat_hi", 64'(io_mem[OUT_BASE + 0]), 64'h7FFF);
        check_eq("sat_lo", 64'(io_mem[OUT_BASE + 1]), 64'h8000);

        // Back-to-back with Start held high.
        for (int i = 0; i < N_IN; i++) io_mem[IN_BASE + i] = 16'($urandom);
        run_pass(1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-READ, then a fresh pass.
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
        check_eq("mid_rst_wren", 64'(bus.io_wren), 64'd0);
        check_eq("mid_rst_io_addr", 64'(bus.io_address), 64'd0);
        check_eq("mid_rst_w_addr", 64'(|bus.w_address), 64'd0);
        check_eq("mid_rst_done", 64'(bus.done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_IN; i++) io_mem[IN_BASE + i] = 16'((i + 1) * 256);
        for (int i = 0; i < N_IN; i++) w_mem[0][i] = 16'h0100;
        w_mem[0][N_IN] = 16'h0080;
        run_pass(1'b1, 1'b0, 1'b0);
        check_eq("post_rst_lane0", 64'(io_mem[OUT_BASE + 0]), 64'h0A80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
